// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer and the downstream counter stage.
// Holds the FSM state encoding and the 12 MHz board timing defaults.
// No logic here; constants and a small helper only.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Board clock and the default debounce / auto-repeat timings derived from it.
   localparam int DEF_CLK_HZ        = 12_000_000;
   localparam int DEF_STABLE_CYCLES = DEF_CLK_HZ / 20;  // 50 ms
   localparam int DEF_REPEAT_DELAY  = DEF_CLK_HZ / 2;   // 500 ms
   localparam int DEF_REPEAT_PERIOD = DEF_CLK_HZ / 10;  // 100 ms

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button pin and conditioned outputs bundled between the board side and the debouncer.
// Purely wiring; no latency.
// No flow control: the pin is free-running and the outputs are level/pulse signals.
interface button_debouncer_if;
   logic pmod;           // raw pin, active-low, asynchronous
   logic pressed;        // debounced level
   logic press;          // one-cycle press (and repeat) pulse
   logic release_pulse;  // one-cycle release pulse ("release" is a reserved word)

   modport master (output pmod, input pressed, input press, input release_pulse);
   modport slave  (input pmod, output pressed, output press, output release_pulse);
endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous PMOD inputs.
// Latency: 2 clk cycles from input to q.
// No backpressure; samples every cycle, both stages reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // Two-stage capture of the asynchronous input; both stages clear on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/button_debouncer.sv
// Debounces the active-low PMOD button into a level plus press/release pulses.
// Latency: STABLE_CYCLES+2 cycles from the first edge sampling the new pin level.
// No backpressure; optional auto-repeat under BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input logic               clk,
   input logic               rst,
   button_debouncer_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic          raw_s;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed_q, pressed_d;
   logic          press_q, press_d, press_nxt;
   logic          rel_q, rel_d;

   // Pin is inverted before synchronizing so raw_s=1 means "button down".
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (~bus.pmod),
      .q   (raw_s)
   );

   // Next-state logic: a transition is accepted only after the counter sees a full stable run.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
      case (state_q)
         RELEASED: begin
            if (raw_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!raw_s) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = HELD;
               press_d   = 1'b1;
               pressed_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!raw_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (raw_s) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RELEASED;
               rel_d     = 1'b1;
               pressed_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [RW-1:0] rcnt_q, rcnt_d, rthr;
   logic          rphase_q, rphase_d;  // 0: waiting for first repeat, 1: periodic repeats
   logic          holding, rep_fire;

   // Repeat timer runs while the button is accepted as down; a repeat colliding with release acceptance is dropped.
   always_comb begin
      holding  = (state_q == HELD) || (state_q == RELEASE_WAIT);
      rthr     = rphase_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
      rcnt_d   = rcnt_q;
      rphase_d = rphase_q;
      rep_fire = 1'b0;
      if (press_d) begin
         rcnt_d   = '0;
         rphase_d = 1'b0;
      end else if (holding) begin
         if (rcnt_q == rthr) begin
            rep_fire = !rel_d;
            rcnt_d   = '0;
            rphase_d = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q   <= '0;
         rphase_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_d;
         rphase_q <= rphase_d;
      end
   end

   assign press_nxt = press_d | rep_fire;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
   assign press_nxt = press_d;
`endif

   // State, counter and registered outputs; reset abandons any qualification silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         rel_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         press_q   <= press_nxt;
         rel_q     <= rel_d;
      end
   end

   assign bus.pressed       = pressed_q;
   assign bus.press         = press_q;
   assign bus.release_pulse = rel_q;
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw active-low push-button input from the PMOD header into clean, single-clock-domain control signals. It sits directly upstream of the LED counter stage. It replaces direct use of the bouncing pin with three outputs: a debounced level, a one-cycle press pulse, and a one-cycle release pulse. Optional auto-repeat turns a held button into a periodic stream of press pulses.

## Interface
Parameters:
- STABLE_CYCLES, 600000: consecutive stable synchronized samples required to accept a transition. At 12 MHz this is 50 ms. Must be ≥ 1.
- REPEAT_DELAY, 6000000: cycles in HELD after the initial press before the first repeat pulse. Used only with auto-repeat. Must be ≥ 1.
- REPEAT_PERIOD, 1200000: cycles between subsequent repeat pulses. Used only with auto-repeat. Must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous active-high reset.
- pmod  in  1  raw button pin, asynchronous and active-low (0 = pressed).
- pressed  out  1  debounced level; 1 while the button is accepted as held.
- press  out  1  one-cycle pulse on an accepted press, plus repeat pulses when enabled.
- release  out  1  one-cycle pulse on an accepted release.

## Operation
- Synchronizer: two flops sample ~pmod. Both reset to 0 (released). Their output is raw_s.
- Stability counter cnt: width $clog2(STABLE_CYCLES+1). It does not wrap, because a state exit always occurs at STABLE_CYCLES-1.
- FSM states and transitions:
  - RELEASED: if raw_s=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - raw_s=0 (bounce): return to RELEASED. No output activity.
    - raw_s=1 and cnt==STABLE_CYCLES-1: go to HELD. Register press=1 for one cycle and pressed=1.
    - Otherwise: cnt+1.
  - HELD: if raw_s=0, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT:
    - raw_s=1 (bounce): return to HELD. pressed stays 1 and no pulse is emitted.
    - raw_s=0 and cnt==STABLE_CYCLES-1: go to RELEASED. Register release=1 for one cycle and pressed=0.
    - Otherwise: cnt+1.
- press and release are never high in the same cycle. Each is high for exactly one cycle per event.
- Reset:
  - Reset values: state=RELEASED, cnt=0, synchronizer=0, pressed=0, press=0, release=0.
  - Reset mid-qualification abandons the qualification with no pulse.
  - Reset while HELD drops pressed without a release pulse.
  - A button held through reset deassertion is re-qualified and yields a normal press pulse STABLE_CYCLES+2 cycles later.
- Any pmod pulse shorter than STABLE_CYCLES synchronized samples produces no output change.

## Timing
- Edge 0 is the first rising edge that samples pmod=0.
  - raw_s=1 after edge 1.
  - PRESS_WAIT is entered at edge 2.
  - press and pressed are registered at edge STABLE_CYCLES+2.
- Release latency is identical, measured from the first edge sampling pmod=1.
- All outputs are registered. There is no combinational path from pmod to any output.

## Configuration
- Macro: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - A repeat counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), clears on entry to HELD.
  - It counts only in HELD and RELEASE_WAIT; a bounce back to HELD does not clear it.
  - A press pulse is emitted when the counter reaches REPEAT_DELAY-1. The counter then reloads, and a further press pulse fires every REPEAT_PERIOD cycles while the state is HELD.
  - Leaving to RELEASED stops repeats immediately.
  - A repeat due in the same cycle as the release acceptance is suppressed.
- Undefined: no repeat counter exists, REPEAT_* parameters are ignored, and exactly one press pulse is emitted per accepted press.

## Structure
- A shared package/header holds:
  - the FSM state encoding (RELEASED=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - the default timing constants for the 12 MHz board clock, reused by the downstream counter stage.
- One sub-module: sync_2ff, a generic two-flop synchronizer with synchronous reset value 0, reused for other PMOD inputs.

## Test plan
All scenarios use STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: pmod 1→0 and held. Required response: press high for exactly one cycle after edge 6, pressed=1 from edge 6.
- Bounce: pmod toggles 0,1,0,1 with a 2-cycle period, then settles at 0. Required response: no pulse during the bouncing; a single press pulse 6 edges after the final falling sample.
- Glitch while held: pmod returns to 1 for 3 cycles, then goes back to 0. Required response: pressed stays 1, no release pulse, no extra press pulse.
- Clean release after hold: pmod 0→1. Required response: release high for exactly one cycle after edge 6, pressed=0.
- Reset while HELD: assert rst for 1 cycle. Required response: all outputs 0 on the next edge, no release pulse. Keep pmod=0 through reset deassertion; required response: a press pulse 6 cycles after deassertion.
- With BUTTON_DEBOUNCER_AUTOREPEAT_EN, hold the button for 30 cycles after the press pulse. Required response: press pulses at 10, 13, 16, … cycles after the HELD entry edge, stopping on release. Without the macro, the same stimulus must give a single press pulse.
